instruction_fetch_stage: RTL and testbench

//  Program counter and instruction-fetch stage of the 8-bit pipelined processor.
//  - Holds the PC and reads a local 20-bit instruction memory.
//  - Registers the fetched word into the IF/ID pipeline register, where the

---
 rtl/instruction_fetch_stage.sv | 121 ++++++++++++
 tb/tb_instruction_fetch_stage.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_stage.sv
//------------------------------------------------------------------------------
// instruction_fetch_stage
//   Program counter and instruction-fetch stage of the 8-bit pipelined
//   processor. Holds the PC, reads a local instruction memory with a
//   combinational read, and registers the fetched word into the IF/ID
//   pipeline register for the jump control block to decode. A redirect from
//   that block (pc_mux_sel / jmp_loc) loads the PC with the target.
//
//   Optional feature macro: FETCH_FLUSH_EN
//     defined   : a taken redirect squashes the wrong-path word (NOP, valid=0)
//     undefined : the word fetched alongside the jump enters IF/ID normally,
//                 giving a one-instruction branch delay slot
//
// Ports
//   clk              in   rising-edge clock
//   reset            in   synchronous, active-low reset
//   stall            in   hold PC and IF/ID this cycle
//   pc_mux_sel       in   redirect request from jump control block
//   jmp_loc          in   redirect target address
//   imem_we          in   instruction memory write enable (loader)
//   imem_waddr       in   instruction memory write address
//   imem_wdata       in   instruction memory write data
//   ins_id           out  IF/ID instruction
//   pc_id            out  address of ins_id
//   valid_id         out  ins_id is a real fetched instruction
//   current_address  out  fetch PC (the pc register itself)
//------------------------------------------------------------------------------
module instruction_fetch_stage #(
  parameter int              ADDR_W     = 8,
  parameter int              INS_W      = 20,
  parameter int              IMEM_DEPTH = 256,
  parameter logic [INS_W-1:0] NOP_INS   = 20'h00000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              pc_mux_sel,
  input  logic [ADDR_W-1:0] jmp_loc,
  input  logic              imem_we,
  input  logic [ADDR_W-1:0] imem_waddr,
  input  logic [INS_W-1:0]  imem_wdata,
  output logic [INS_W-1:0]  ins_id,
  output logic [ADDR_W-1:0] pc_id,
  output logic              valid_id,
  output logic [ADDR_W-1:0] current_address
);

  logic [INS_W-1:0]  imem_r [IMEM_DEPTH];
  logic [ADDR_W-1:0] pc_r;
  logic [INS_W-1:0]  ins_id_r;
  logic [ADDR_W-1:0] pc_id_r;
  logic              valid_id_r;

  logic [INS_W-1:0]  ins_if_s;
  logic [ADDR_W-1:0] pc_next_s;
  logic [INS_W-1:0]  ins_id_next_s;
  logic [ADDR_W-1:0] pc_id_next_s;
  logic              valid_id_next_s;

  // Loader write port; memory is never cleared and ignores stall and reset.
  always_ff @(posedge clk) begin
    if (imem_we) begin
      imem_r[imem_waddr] <= imem_wdata;
    end
  end

  // Zero-latency fetch; a same-cycle write is seen only from the next cycle.
  assign ins_if_s = imem_r[pc_r];

  // Next PC and IF/ID contents; a stall holds everything and ignores redirect.
  always_comb begin
    pc_next_s       = pc_r;
    ins_id_next_s   = ins_id_r;
    pc_id_next_s    = pc_id_r;
    valid_id_next_s = valid_id_r;
    if (!stall) begin
      // Increment wraps naturally at the ADDR_W boundary.
      pc_next_s    = pc_mux_sel ? jmp_loc : (pc_r + {{(ADDR_W-1){1'b0}}, 1'b1});
      pc_id_next_s = pc_r;
`ifdef FETCH_FLUSH_EN
      if (pc_mux_sel) begin
        // The word at pc is on the wrong path once a jump is taken.
        ins_id_next_s   = NOP_INS;
        valid_id_next_s = 1'b0;
      end else begin
        ins_id_next_s   = ins_if_s;
        valid_id_next_s = 1'b1;
      end
`else
      ins_id_next_s   = ins_if_s;
      valid_id_next_s = 1'b1;
`endif
    end else begin
      pc_next_s       = pc_r;
      ins_id_next_s   = ins_id_r;
      pc_id_next_s    = pc_id_r;
      valid_id_next_s = valid_id_r;
    end
  end

  // PC and IF/ID registers; reset wins over stall and any pending redirect.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_r       <= {ADDR_W{1'b0}};
      ins_id_r   <= NOP_INS;
      pc_id_r    <= {ADDR_W{1'b0}};
      valid_id_r <= 1'b0;
    end else begin
      pc_r       <= pc_next_s;
      ins_id_r   <= ins_id_next_s;
      pc_id_r    <= pc_id_next_s;
      valid_id_r <= valid_id_next_s;
    end
  end

  assign ins_id          = ins_id_r;
  assign pc_id           = pc_id_r;
  assign valid_id        = valid_id_r;
  assign current_address = pc_r;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
module tb_instruction_fetch_stage;

  localparam logic [19:0] NOP = 20'h00000;
`ifdef FETCH_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, stall, pc_mux_sel, imem_we;
  logic [7:0]  jmp_loc, imem_waddr;
  logic [19:0] imem_wdata;
  logic [19:0] ins_id;
  logic [7:0]  pc_id, current_address;
  logic        valid_id;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [19:0] m_mem [256];
  logic [7:0]  m_pc, m_pcid;
  logic [19:0] m_ins;
  logic        m_v;

  always #5 clk = ~clk;

  instruction_fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .pc_mux_sel(pc_mux_sel),
    .jmp_loc(jmp_loc), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .ins_id(ins_id), .pc_id(pc_id),
    .valid_id(valid_id), .current_address(current_address)
  );

  // One clock of stimulus; the model advances with the same inputs.
  task automatic step(input logic r, input logic st, input logic sel,
                      input logic [7:0] jl, input logic we,
                      input logic [7:0] wa, input logic [19:0] wd);
    logic [19:0] fetched;
    reset = r; stall = st; pc_mux_sel = sel; jmp_loc = jl;
    imem_we = we; imem_waddr = wa; imem_wdata = wd;
    @(posedge clk);
    fetched = m_mem[m_pc];
    if (!r) begin
      m_pc = 8'h00; m_ins = NOP; m_pcid = 8'h00; m_v = 1'b0;
    end else if (!st) begin
      m_pcid = m_pc;
      if (FLUSH && sel) begin m_ins = NOP; m_v = 1'b0; end
      else begin m_ins = fetched; m_v = 1'b1; end
      m_pc = sel ? jl : 8'((int'(m_pc) + 1) % 256);
    end
    if (we) m_mem[wa] = wd;
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 256; i++) begin
      logic [19:0] w;
      w = (i == 5) ? 20'h12345 : 20'($urandom);
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'(i), w);
    end
    step(1'b0, 1'b1, 1'b1, 8'h33, 1'b0, 8'h00, 20'h0);
    step(1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 8'h00, 20'h0);
    n_checks++; if (current_address !== 8'h00) begin n_fail++; $display("FAIL reset_pc got %h exp 00", current_address); end
    n_checks++; if (ins_id !== NOP) begin n_fail++; $display("FAIL reset_ins got %h exp %h", ins_id, NOP); end
    n_checks++; if (valid_id !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", valid_id); end
    n_checks++; if (pc_id !== 8'h00) begin n_fail++; $display("FAIL reset_pcid got %h exp 00", pc_id); end
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 20'h0);
    n_checks++; if (ins_id !== m_mem[0]) begin n_fail++; $display("FAIL release_ins got %h exp %h", ins_id, m_mem[0]); end
    n_checks++; if (pc_id !== 8'h00 || valid_id !== 1'b1) begin n_fail++; $display("FAIL release_pcid got %h/%b exp 00/1", pc_id, valid_id); end
    n_checks++; if (current_address !== 8'h01) begin n_fail++; $display("FAIL release_pc got %h exp 01", current_address); end
  endtask

  task automatic test_sequential_wrap;
    step(1'b1, 1'b0, 1'b1, 8'hFE, 1'b0, 8'h00, 20'h0);
    n_checks++; if (current_address !== 8'hFE) begin n_fail++; $display("FAIL seq_start got %h exp fe", current_address); end
    for (int k = 0; k < 4; k++) begin
      logic [7:0] e;
      e = 8'hFE + 8'(k);
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 20'h0);
      n_checks++;
      if (pc_id !== e || ins_id !== m_mem[e] || valid_id !== 1'b1) begin
        n_fail++; $display("FAIL seq_wrap got %h/%h/%b exp %h/%h/1", pc_id, ins_id, valid_id, e, m_mem[e]);
      end
    end
  endtask

  task automatic test_jump;
    step(1'b1, 1'b0, 1'b1, 8'h10, 1'b0, 8'h00, 20'h0);
    step(1'b1, 1'b0, 1'b1, 8'h40, 1'b0, 8'h00, 20'h0);
    n_checks++; if (current_address !== 8'h40) begin n_fail++; $display("FAIL jump_pc got %h exp 40", current_address); end
    n_checks++;
    if (FLUSH) begin
      if (ins_id !== NOP || valid_id !== 1'b0 || pc_id !== 8'h10) begin
        n_fail++; $display("FAIL jump_flush got %h/%b/%h exp %h/0/10", ins_id, valid_id, pc_id, NOP);
      end
    end else begin
      if (ins_id !== m_mem[8'h10] || valid_id !== 1'b1 || pc_id !== 8'h10) begin
        n_fail++; $display("FAIL jump_delay got %h/%b/%h exp %h/1/10", ins_id, valid_id, pc_id, m_mem[8'h10]);
      end
    end
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 20'h0);
    n_checks++;
    if (ins_id !== m_mem[8'h40] || pc_id !== 8'h40 || valid_id !== 1'b1) begin
      n_fail++; $display("FAIL jump_target got %h/%h exp %h/40", ins_id, pc_id, m_mem[8'h40]);
    end
  endtask

  task automatic test_stall_redirect;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, 1'b1, 8'h22, 1'b0, 8'h00, 20'h0);
      n_checks++;
      if (current_address !== 8'h41 || pc_id !== 8'h40 || ins_id !== m_mem[8'h40] || valid_id !== 1'b1) begin
        n_fail++; $display("FAIL stall_hold got %h/%h/%h exp 41/40/%h", current_address, pc_id, ins_id, m_mem[8'h40]);
      end
    end
    step(1'b1, 1'b0, 1'b1, 8'h22, 1'b0, 8'h00, 20'h0);
    n_checks++; if (current_address !== 8'h22) begin n_fail++; $display("FAIL stall_release got %h exp 22", current_address); end
  endtask

  task automatic test_collision;
    step(1'b1, 1'b0, 1'b1, 8'h05, 1'b0, 8'h00, 20'h0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h05, 20'hABCDE);
    n_checks++; if (ins_id !== 20'h12345 || pc_id !== 8'h05) begin n_fail++; $display("FAIL collide_old got %h/%h exp 12345/05", ins_id, pc_id); end
    step(1'b1, 1'b0, 1'b1, 8'h05, 1'b0, 8'h00, 20'h0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 20'h0);
    n_checks++; if (ins_id !== 20'hABCDE || pc_id !== 8'h05) begin n_fail++; $display("FAIL collide_new got %h/%h exp abcde/05", ins_id, pc_id); end
  endtask

  task automatic test_midrun_reset;
    step(1'b0, 1'b0, 1'b1, 8'hF0, 1'b0, 8'h00, 20'h0);
    n_checks++;
    if (current_address !== 8'h00 || valid_id !== 1'b0 || ins_id !== NOP || pc_id !== 8'h00) begin
      n_fail++; $display("FAIL midrst got %h/%b/%h/%h exp 00/0/%h/00", current_address, valid_id, ins_id, pc_id, NOP);
    end
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 20'h0);
    n_checks++; if (current_address !== 8'h01 || pc_id !== 8'h00) begin n_fail++; $display("FAIL midrst_lost got %h/%h exp 01/00", current_address, pc_id); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 600; i++) begin
      logic r, st, sel, we;
      logic [7:0] jl, wa;
      r   = ($urandom_range(99) >= 2);
      st  = ($urandom_range(99) < 25);
      sel = ($urandom_range(99) < 15);
      jl  = ($urandom_range(3) == 0) ? 8'hF0 : 8'($urandom);
      we  = ($urandom_range(99) < 20);
      wa  = ($urandom_range(1) == 0) ? m_pc : 8'($urandom);
      step(r, st, sel, jl, we, wa, 20'($urandom));
      n_checks++;
      if (current_address !== m_pc || pc_id !== m_pcid || ins_id !== m_ins || valid_id !== m_v) begin
        n_fail++;
        $display("FAIL rand_%0d got pc=%h pcid=%h ins=%h v=%b exp pc=%h pcid=%h ins=%h v=%b",
                 i, current_address, pc_id, ins_id, valid_id, m_pc, m_pcid, m_ins, m_v);
      end
    end
  endtask

  initial begin
    m_pc = 8'h00; m_pcid = 8'h00; m_ins = NOP; m_v = 1'b0;
    for (int i = 0; i < 256; i++) m_mem[i] = 20'h0;
    reset = 1'b0; stall = 1'b0; pc_mux_sel = 1'b0; jmp_loc = 8'h00;
    imem_we = 1'b0; imem_waddr = 8'h00; imem_wdata = 20'h0;
    #2;
    test_reset;
    test_sequential_wrap;
    test_jump;
    test_stall_redirect;
    test_collision;
    test_midrun_reset;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
